// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host-side transmitter: FSM states, abort codes,
// keyboard command bytes and the frame builder.
package ps2_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StStart,
        StReq,
        StData,
        StAck,
        StWaitIdle,
        StAbort
    } ps2_state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_NORESP  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_NACK    = 2'b11;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    localparam int unsigned CycCntW   = 21;
    localparam logic [3:0]  FrameBits = 4'd10;

    // {stop, odd parity, data}, shifted out LSB first.
    function automatic logic [9:0] build_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a glitch filter: the output only follows the
// synchronized pin after FILTER_LEN consecutive samples disagree with it.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic board_clk,
    input  logic reset,
    input  logic line_i,
    output logic filt_o
);

    localparam int unsigned CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]      sync_q;
    logic            filt_q, filt_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b11;
            filt_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], line_i};
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync_q[1] != filt_q) begin
            if (cnt_q == CntW'(FILTER_LEN - 1)) begin
                filt_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, frame shift-out on device
// clocks, ACK check, with no-response, frame-timeout and NACK aborts.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 12000,
    parameter int unsigned START_CYCLES   = 500,
    parameter int unsigned REQ_TIMEOUT    = 1500000,
    parameter int unsigned FRAME_TIMEOUT  = 200000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic       board_clk,
    input  logic       reset,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       tx_done_o,
    output logic       tx_error_o,
    output logic [1:0] tx_err_code_o,
    output logic       busy_o,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe_o,
    output logic       ps2_data_oe_o
);

    ps2_state_e         state_q, state_d;
    logic [9:0]         sh_q, sh_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [CycCntW-1:0] cyc_cnt_q, cyc_cnt_d;
    logic               data_oe_q, data_oe_d;
    logic [1:0]         err_code_q, err_code_d;
    logic               clk_prev_q;

    logic clk_filt, data_filt, clk_fall, frame_to;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .board_clk(board_clk),
        .reset    (reset),
        .line_i   (ps2_clk_i),
        .filt_o   (clk_filt)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .board_clk(board_clk),
        .reset    (reset),
        .line_i   (ps2_data_i),
        .filt_o   (data_filt)
    );

    assign clk_fall = clk_prev_q & ~clk_filt;
    assign frame_to = (cyc_cnt_q >= CycCntW'(FRAME_TIMEOUT));

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            sh_q       <= '0;
            bit_cnt_q  <= '0;
            cyc_cnt_q  <= '0;
            data_oe_q  <= 1'b0;
            err_code_q <= ERR_NONE;
            clk_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            bit_cnt_q  <= bit_cnt_d;
            cyc_cnt_q  <= cyc_cnt_d;
            data_oe_q  <= data_oe_d;
            err_code_q <= err_code_d;
            clk_prev_q <= clk_filt;
        end
    end

    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        bit_cnt_d  = bit_cnt_q;
        data_oe_d  = data_oe_q;
        err_code_d = err_code_q;
        cyc_cnt_d  = (&cyc_cnt_q) ? cyc_cnt_q : cyc_cnt_q + 1'b1;
        unique case (state_q)
            StIdle: begin
                cyc_cnt_d = '0;
                if (tx_valid_i) begin
                    sh_d       = build_frame(tx_data_i);
                    bit_cnt_d  = '0;
                    data_oe_d  = 1'b0;
                    err_code_d = ERR_NONE;
                    state_d    = StInhibit;
                end
            end
            StInhibit: begin
                if (cyc_cnt_q >= CycCntW'(INHIBIT_CYCLES - 1)) begin
                    cyc_cnt_d = '0;
                    state_d   = StStart;
                end
            end
            StStart: begin
                if (cyc_cnt_q >= CycCntW'(START_CYCLES - 1)) begin
                    cyc_cnt_d = '0;
                    state_d   = StReq;
                end
            end
            StReq: begin
                if (cyc_cnt_q >= CycCntW'(REQ_TIMEOUT)) begin
                    err_code_d = ERR_NORESP;
                    state_d    = StAbort;
                end else if (clk_fall) begin
                    data_oe_d = ~sh_q[0];
                    sh_d      = {1'b0, sh_q[9:1]};
                    bit_cnt_d = 4'd1;
                    cyc_cnt_d = '0;
                    state_d   = StData;
                end
            end
            StData: begin
                if (frame_to) begin
                    err_code_d = ERR_TIMEOUT;
                    state_d    = StAbort;
                end else if (clk_fall && bit_cnt_q < FrameBits) begin
                    data_oe_d = ~sh_q[0];
                    sh_d      = {1'b0, sh_q[9:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    // Stop bit is a released line; wait for the device ACK.
                    if (bit_cnt_d == FrameBits) begin
                        data_oe_d = 1'b0;
                        state_d   = StAck;
                    end
                end
            end
            StAck: begin
                if (frame_to) begin
                    err_code_d = ERR_TIMEOUT;
                    state_d    = StAbort;
                end else if (clk_fall) begin
                    if (!data_filt) begin
                        state_d = StWaitIdle;
                    end else begin
                        err_code_d = ERR_NACK;
                        state_d    = StAbort;
                    end
                end
            end
            StWaitIdle: begin
                if (frame_to) begin
                    err_code_d = ERR_TIMEOUT;
                    state_d    = StAbort;
                end else if (clk_filt && data_filt) begin
                    state_d = StIdle;
                end
            end
            StAbort: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ps2_clk_oe_o  = 1'b0;
        ps2_data_oe_o = 1'b0;
        tx_done_o     = 1'b0;
        tx_error_o    = 1'b0;
        unique case (state_q)
            StInhibit:  ps2_clk_oe_o = 1'b1;
            StStart: begin
                ps2_clk_oe_o  = 1'b1;
                ps2_data_oe_o = 1'b1;
            end
            StReq:      ps2_data_oe_o = 1'b1;
            StData:     ps2_data_oe_o = data_oe_q;
            StWaitIdle: tx_done_o = ~frame_to & clk_filt & data_filt;
            StAbort:    tx_error_o = 1'b1;
            default:    ;
        endcase
        tx_ready_o    = (state_q == StIdle);
        busy_o        = (state_q != StIdle);
        tx_err_code_o = err_code_q;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. It is the outbound counterpart of the keyboard scan-code receiver and is used to send command bytes to the keyboard, e.g. 0xED (set LEDs), 0xF4 (enable), 0xFF (reset).
- Drives the open-drain PS/2 clock and data lines through output-enable signals. Runs the full request-to-send sequence, shifts the frame out on device-generated clocks, and checks the device ACK.
- Sits beside the receiver at top level. While ps2_clk_oe is high, the receiver must ignore line activity.

Parameters:
- INHIBIT_CYCLES, 12000: board_clk cycles the clock line is held low before the start bit (120 us at 100 MHz).
- START_CYCLES, 500: cycles both lines are held low before the clock is released.
- REQ_TIMEOUT, 1500000: maximum cycles from clock release to the first device falling edge (15 ms).
- FRAME_TIMEOUT, 200000: maximum cycles from the first falling edge to the end of ACK (2 ms).
- FILTER_LEN, 8: consecutive equal synchronized samples required before a filtered line changes.

Ports:
- board_clk, in, 1: system clock, 100 MHz.
- reset, in, 1: asynchronous, active-high.
- tx_data, in, 8: command byte.
- tx_valid, in, 1: request to send tx_data.
- tx_ready, out, 1: high only in IDLE; a transfer is accepted on tx_valid && tx_ready.
- tx_done, out, 1: one-cycle pulse when the frame completes with ACK.
- tx_error, out, 1: one-cycle pulse when the frame is aborted.
- tx_err_code, out, 2: valid with tx_error. 01 = no device response, 10 = frame timeout, 11 = NACK (data high at ACK).
- busy, out, 1: high in every state except IDLE.
- ps2_clk_in, in, 1: raw PS/2 clock pin.
- ps2_data_in, in, 1: raw PS/2 data pin.
- ps2_clk_oe, out, 1: 1 drives the clock line low; 0 releases it (pulled up).
- ps2_data_oe, out, 1: 1 drives the data line low; 0 releases it.

Behaviour:
Reset:
- While reset is high: state = IDLE; tx_ready = 1; tx_done = tx_error = busy = 0; tx_err_code = 00; ps2_clk_oe = ps2_data_oe = 0.
- Lines are released the moment reset asserts, even in the middle of a frame.

Input conditioning:
- Each pin passes through a 2-flop synchronizer, then a FILTER_LEN glitch filter. Filtered values reset to 1.
- fall_strobe is a one-cycle pulse when the filtered clock goes 1 -> 0.

Accept and frame build:
- On accept, latch sh = {1'b1 (stop), ~^tx_data (odd parity), tx_data}, 10 bits, LSB first. Clear bit_cnt and cyc_cnt.
- Next cycle: state = INHIBIT and ps2_clk_oe = 1.

State machine:
- INHIBIT: clk_oe = 1, data_oe = 0 for INHIBIT_CYCLES cycles, then -> START.
- START: clk_oe = 1, data_oe = 1 (start bit 0) for START_CYCLES cycles, then -> REQ with cyc_cnt cleared.
- REQ: clk_oe = 0, data_oe = 1.
  - Timeout: cyc_cnt reaches REQ_TIMEOUT -> ABORT with code 01.
  - First fall_strobe: data_oe = ~sh[0], shift sh, bit_cnt = 1, cyc_cnt cleared, -> DATA.
- DATA: data changes only on fall_strobe (device samples on the rising edge).
  - Falling edges 1..8 present d0..d7, edge 9 presents parity, edge 10 releases data (stop bit).
  - Each fall_strobe: if bit_cnt < 10, data_oe = ~sh[0], shift, bit_cnt++.
  - When bit_cnt == 10 after the shift: data_oe = 0, -> ACK.
- ACK: the next (11th) fall_strobe samples filtered data.
  - Data 0 -> WAIT_IDLE.
  - Data 1 -> ABORT with code 11.
- WAIT_IDLE: when filtered clock = 1 and filtered data = 1, pulse tx_done and go to IDLE.
- FRAME_TIMEOUT: applies in DATA, ACK and WAIT_IDLE, counted from the first falling edge. Expiry -> ABORT with code 10.
- ABORT: lines released; pulse tx_error with tx_err_code; -> IDLE.
  - If a timeout and a fall_strobe land in the same cycle, the timeout wins.

Other rules:
- tx_valid outside IDLE is ignored; no queueing. Back-to-back transfers: tx_ready returns the cycle after tx_done or tx_error.
- Minimum accept-to-clock-release latency is INHIBIT_CYCLES + START_CYCLES + 1 cycles.
- cyc_cnt is 21 bits and saturates. bit_cnt is 4 bits.
- tx_err_code holds its value until the next accept.

Decomposition:
- Shared package ps2_pkg holds:
  - state encoding (IDLE, INHIBIT, START, REQ, DATA, ACK, WAIT_IDLE, ABORT);
  - error codes (ERR_NONE, ERR_NORESP, ERR_TIMEOUT, ERR_NACK);
  - keyboard command constants (CMD_SET_LEDS = 8'hED, CMD_ENABLE = 8'hF4, CMD_RESET = 8'hFF).
- One sub-module, ps2_line_filter (synchronizer plus glitch filter, FILTER_LEN parameter), instantiated twice: once for the clock line, once for the data line.

Test Plan:
- Device BFM with 40 us clock period sees tx_data = 0xED:
  - clk_oe high for exactly 12000 cycles, then both lines low for 500 cycles.
  - After falling edges 1..9, data_oe = 0,1,0,0,1,0,0,0,0 (bits 1,0,1,1,0,1,1,1, parity 1).
  - BFM ACK low -> tx_done pulses once; tx_error = 0.
- tx_data = 0xF4: BFM captures byte 0xF4 with parity bit 0 and stop bit 1; after tx_done, tx_ready = 1 the next cycle.
- BFM never clocks: after 1500000 cycles in REQ, tx_error = 1 with code 01; both oe = 0.
- BFM leaves data high at the 11th edge: tx_error pulses with code 11. BFM stops clocking after edge 5: tx_error pulses with code 10 exactly 200000 cycles after edge 1.
- Reset asserted after edge 4: both oe = 0 asynchronously. After reset deasserts, tx_ready = 1 and a new 0xFF transfer completes with tx_done.
- Glitch rejection: 3-cycle low glitches on ps2_clk_in during DATA produce no bit advance; a tx_valid pulse mid-frame is ignored and the frame still completes correctly.
